// File: rtl/mem_pkg.sv
// Shared constants for the unified memory responder: MMIO register offsets
// and the program-loader state encoding.
package mem_pkg;

  localparam logic [3:0] IO_LED    = 4'h0;
  localparam logic [3:0] IO_SW     = 4'h4;
  localparam logic [3:0] IO_CYCLE  = 4'h8;
  localparam logic [3:0] IO_STATUS = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH
  } ld_state_e;

endpackage

// File: rtl/ram_sp_async.sv
// Word RAM with one synchronous write port and one combinational read port.
// Contents are deliberately not reset.
module ram_sp_async #(
  parameter int unsigned Width      = 32,
  parameter int unsigned DepthWords = 256,
  parameter int unsigned AddrWidth  = $clog2(DepthWords)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_waddr,
  input  logic [Width-1:0]     i_wdata,
  input  logic [AddrWidth-1:0] i_raddr,
  output logic [Width-1:0]     o_rdata
);

  logic [Width-1:0] r_mem [DepthWords];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/unified_mem_responder.sv
// Memory-side responder for a unified-bus core: word RAM, small MMIO window
// and a host program loader that holds the core in reset while filling RAM.
module unified_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned       Width       = 32,
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter logic [Width-1:0]  IO_BASE     = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] mem_adr,
  input  logic [Width-1:0] mem_wdata,
  input  logic             mem_we,
  output logic [Width-1:0] mem_rdata,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [Width-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             ld_done,
  output logic             core_hold,
  input  logic [15:0]      sw_in,
  output logic [15:0]      led_out
);

  localparam int unsigned   AW      = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH_WORDS - 1);

  ld_state_e        r_state;
  logic [AW-1:0]    r_ptr;
  logic             r_ld_ready;
  logic             r_ld_done;
  logic             r_core_hold;
  logic             r_load_seen;
  logic [15:0]      r_led;
  logic [15:0]      r_sw_meta;
  logic [15:0]      r_sw_sync;
  logic [Width-1:0] r_cycle;

  logic             w_io_hit;
  logic             w_io_reg_hit;
  logic [3:0]       w_io_off;
  logic             w_core_we;
  logic             w_core_ram_we;
  logic             w_led_we;
  logic             w_ld_we;
  logic             w_ram_we;
  logic [AW-1:0]    w_ram_waddr;
  logic [Width-1:0] w_ram_wdata;
  logic [Width-1:0] w_ram_rdata;
  logic [Width-1:0] w_io_rdata;
  logic             w_unused_adr;

  // Byte-lane bits are not meaningful on a word bus.
  assign w_unused_adr = ^mem_adr[1:0];

  assign w_io_hit     = (mem_adr[31:16] == IO_BASE[31:16]);
  assign w_io_reg_hit = w_io_hit && (mem_adr[15:4] == 12'h000);
  assign w_io_off     = {mem_adr[3:2], 2'b00};

  // Core stores are gated by hold so they can never race the loader.
  assign w_core_we     = mem_we & ~r_core_hold;
  assign w_core_ram_we = w_core_we & ~w_io_hit;
  assign w_led_we      = w_core_we & w_io_reg_hit & (w_io_off == IO_LED);
  assign w_ld_we       = (r_state == S_LOAD) & ld_valid & r_ld_ready;

  assign w_ram_we    = w_ld_we | w_core_ram_we;
  assign w_ram_waddr = w_ld_we ? r_ptr : mem_adr[AW+1:2];
  assign w_ram_wdata = w_ld_we ? ld_data : mem_wdata;

  ram_sp_async #(
    .Width      (Width),
    .DepthWords (DEPTH_WORDS),
    .AddrWidth  (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (mem_adr[AW+1:2]),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_io_rdata = '0;
    if (w_io_reg_hit) begin
      case (w_io_off)
        IO_LED:    w_io_rdata = {{(Width-16){1'b0}}, r_led};
        IO_SW:     w_io_rdata = {{(Width-16){1'b0}}, r_sw_sync};
        IO_CYCLE:  w_io_rdata = r_cycle;
        IO_STATUS: w_io_rdata = {{(Width-2){1'b0}}, r_core_hold, r_load_seen};
        default:   w_io_rdata = '0;
      endcase
    end
  end

  assign mem_rdata = w_io_hit ? w_io_rdata : w_ram_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_cycle   <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      r_cycle   <= r_cycle + 1'b1;
      if (w_led_we) begin
        r_led <= mem_wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_ld_ready  <= 1'b0;
      r_ld_done   <= 1'b0;
      r_core_hold <= 1'b0;
      r_load_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ld_done <= 1'b0;
          if (ld_start) begin
            r_state     <= S_LOAD;
            r_ptr       <= '0;
            r_ld_ready  <= 1'b1;
            r_core_hold <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_ld_we) begin
            r_ptr <= r_ptr + 1'b1;
            if (ld_last || (r_ptr == PTR_MAX)) begin
              r_state    <= S_FLUSH;
              r_ld_ready <= 1'b0;
              r_ld_done  <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          r_state     <= S_IDLE;
          r_ld_done   <= 1'b0;
          r_core_hold <= 1'b0;
          r_load_seen <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_ld_ready  <= 1'b0;
          r_ld_done   <= 1'b0;
          r_core_hold <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready  = r_ld_ready;
  assign ld_done   = r_ld_done;
  assign core_hold = r_core_hold;
  assign led_out   = r_led;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench: stimulus pushes expected values into a scoreboard queue and
// a negedge monitor drains and compares them against the live DUT outputs.
module tb_unified_mem_responder;

  localparam int K_RDATA = 0;
  localparam int K_LED   = 1;
  localparam int K_HOLD  = 2;
  localparam int K_READY = 3;
  localparam int K_DONE  = 4;

  logic        clk;
  logic        reset;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        core_hold;
  logic [15:0] sw_in;
  logic [15:0] led_out;

  int          checks;
  int          errors;
  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];

  unified_mem_responder #(
    .Width       (32),
    .DEPTH_WORDS (256),
    .IO_BASE     (32'hFFFF_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .core_hold (core_hold),
    .sw_in     (sw_in),
    .led_out   (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  task automatic expect_rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
    mem_adr = adr;
    expect_val(K_RDATA, exp, name);
  endtask

  // Monitor: inputs only change just after posedge, so negedge sees settled outputs.
  always @(negedge clk) begin
    while (q_kind.size() > 0) begin
      int          kind;
      logic [31:0] exp;
      logic [31:0] act;
      string       name;
      kind = q_kind.pop_front();
      exp  = q_exp.pop_front();
      name = q_name.pop_front();
      case (kind)
        K_RDATA: act = mem_rdata;
        K_LED:   act = {16'h0000, led_out};
        K_HOLD:  act = {31'd0, core_hold};
        K_READY: act = {31'd0, ld_ready};
        default: act = {31'd0, ld_done};
      endcase
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    sw_in     = 16'h0000;

    // 1. Reset for 3 edges, then watch the cycle counter.
    tick(); tick(); tick();
    reset = 1'b1;
    expect_val(K_LED, 32'h0, "reset_led");
    expect_val(K_HOLD, 32'h0, "reset_hold");
    expect_val(K_READY, 32'h0, "reset_ready");
    expect_val(K_DONE, 32'h0, "reset_done");
    expect_rd(32'hFFFF_0008, 32'd0, "cycle_at_release");
    tick();
    expect_rd(32'hFFFF_0008, 32'd1, "cycle_1");
    tick();
    expect_rd(32'hFFFF_0008, 32'd2, "cycle_2");
    tick();
    expect_rd(32'hFFFF_0008, 32'd3, "cycle_3");
    tick();

    // 2. RAM store, read back, and alias read.
    mem_adr = 32'h0000_0010; mem_wdata = 32'hDEAD_BEEF; mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
    expect_rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    tick();
    expect_rd(32'h0000_0410, 32'hDEAD_BEEF, "ram_alias");
    tick();
    expect_rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_byte_bits_ignored");
    tick();

    // 3. LED write, RO write ignored, switch synchroniser, unmapped IO.
    mem_adr = 32'hFFFF_0000; mem_wdata = 32'h1234_ABCD; mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
    expect_val(K_LED, 32'h0000_ABCD, "led_write");
    expect_rd(32'hFFFF_0000, 32'h0000_ABCD, "led_read");
    tick();
    mem_adr = 32'hFFFF_0004; mem_wdata = 32'h0000_5555; mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
    expect_val(K_LED, 32'h0000_ABCD, "led_ro_write_ignored");
    sw_in = 16'hA5C3;
    expect_rd(32'hFFFF_0004, 32'h0, "sw_sync_0");
    tick();
    expect_rd(32'hFFFF_0004, 32'h0, "sw_sync_1");
    tick();
    expect_rd(32'hFFFF_0004, 32'h0000_A5C3, "sw_sync_2");
    tick();
    expect_rd(32'hFFFF_0010, 32'h0, "io_unmapped");
    tick();

    // 4. Program load of four words with valid gaps.
    expect_rd(32'hFFFF_000C, 32'h0, "status_before_load");
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    expect_val(K_READY, 32'h1, "load_ready");
    expect_val(K_HOLD, 32'h1, "load_hold");
    tick();
    ld_valid = 1'b1; ld_data = 32'h11;
    tick();
    ld_data = 32'h22;
    tick();
    ld_valid = 1'b0;
    expect_val(K_DONE, 32'h0, "no_done_in_gap");
    tick();
    ld_valid = 1'b1; ld_data = 32'h33;
    tick();
    ld_data = 32'h44; ld_last = 1'b1;
    expect_val(K_READY, 32'h1, "ready_last_word");
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    expect_val(K_DONE, 32'h1, "flush_done");
    expect_val(K_HOLD, 32'h1, "flush_hold");
    expect_val(K_READY, 32'h0, "flush_ready");
    expect_rd(32'hFFFF_000C, 32'h2, "status_in_flush");
    tick();
    expect_val(K_DONE, 32'h0, "done_pulse_end");
    expect_val(K_HOLD, 32'h0, "hold_released");
    expect_rd(32'hFFFF_000C, 32'h1, "status_after_load");
    tick();
    expect_rd(32'h0000_0000, 32'h11, "load_w0");
    tick();
    expect_rd(32'h0000_0004, 32'h22, "load_w1");
    tick();
    expect_rd(32'h0000_0008, 32'h33, "load_w2");
    tick();
    expect_rd(32'h0000_000C, 32'h44, "load_w3");
    tick();

    // 5. Core store suppressed during load; mid-load ld_start ignored.
    mem_adr = 32'h0000_0020; mem_wdata = 32'hCAFE_F00D; mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    mem_adr = 32'h0000_0020; mem_wdata = 32'hBAD0_BAD0; mem_we = 1'b1;
    ld_valid = 1'b1; ld_data = 32'hA1;
    tick();
    ld_start = 1'b1; ld_data = 32'hA2;
    tick();
    ld_start = 1'b0; ld_data = 32'hA3; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    expect_val(K_DONE, 32'h1, "load2_done");
    tick();
    mem_we = 1'b0;
    expect_rd(32'h0000_0020, 32'hCAFE_F00D, "core_store_suppressed");
    tick();
    expect_rd(32'h0000_0000, 32'hA1, "load2_w0");
    tick();
    expect_rd(32'h0000_0004, 32'hA2, "load2_w1_ptr_continues");
    tick();
    expect_rd(32'h0000_0008, 32'hA3, "load2_w2");
    tick();
    expect_rd(32'h0000_000C, 32'h44, "load2_w3_untouched");
    tick();

    // 6. Reset mid-load aborts without a done pulse.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hB1;
    tick();
    ld_data = 32'hB2;
    tick();
    ld_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    expect_val(K_HOLD, 32'h0, "abort_hold");
    expect_val(K_READY, 32'h0, "abort_ready");
    expect_val(K_DONE, 32'h0, "abort_done");
    expect_val(K_LED, 32'h0, "abort_led_reset");
    expect_rd(32'hFFFF_000C, 32'h0, "abort_status");
    tick();
    expect_val(K_DONE, 32'h0, "abort_no_done_later");
    expect_rd(32'h0000_0000, 32'hB1, "abort_ram_kept");
    tick();
    tick();

    checks++;
    if (q_kind.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_kind.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
